iicmb_seq: RTL and testbench
============================

IICMB_SEQ -- requirements
Module: iicmb_seq

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- WB_ADDR_WIDTH, 2, Wishbone address width
- WB_DATA_WIDTH, 8, Wishbone data width
- I2C_ADDR_WIDTH, 7, I2C slave address width
- LEN_WIDTH, 6, transfer length width
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk_i, in, 1, single clock
- rst_i, in, 1, reset, asynchronous, active-low
- req_valid, in, 1, transaction request
- req_ready, out, 1, request accepted when high with req_valid
- req_rw, in, 1, 0 = write, 1 = read
- req_bus, in, 4, I2C bus number
- req_addr, in, I2C_ADDR_WIDTH, slave address
- req_len, in, LEN_WIDTH, data byte count (0 = address-only probe)
- wr_valid, in, 1, write byte available
- wr_ready, out, 1, write byte consumed
- wr_data, in, 8, write byte
- rd_valid, out, 1, one-cycle read byte strobe
- rd_data, out, 8, read byte
- done, out, 1, one-cycle transaction completion pulse
- err, out, 2, status: 00 ok, 01 NAK, 10 arbitration lost, 11 controller error
- busy, out, 1, transaction in progress
- cyc_o, stb_o, we_o, out, 1 each, Wishbone master controls
- adr_o, out, WB_ADDR_WIDTH, register select: CSR = 0, DPR = 1, CMDR = 2
- dat_o, out, WB_DATA_WIDTH, write data
- dat_i, in, WB_DATA_WIDTH, read data
- ack_i, in, 1, Wishbone acknowledge
- irq_i, in, 1, IICMB interrupt

Function
REQ-003 Wishbone cycle: cyc_o, stb_o, we_o, adr_o and dat_o are held stable until the clock edge sampling ack_i=1; cyc_o and stb_o are low for at least 1 cycle between accesses; there is no timeout.
REQ-004 After reset release, the block first performs WB write CSR=0xC0 (enable core and irq). req_ready stays 0 until this write is acked.
REQ-005 req_ready=1 only in IDLE; on handshake, req_* are latched and busy=1 on the next cycle.
REQ-006 Command codes written to CMDR: SET_BUS=0x06, START=0x04, WRITE=0x01, STOP=0x05, READ_ACK=0x02, READ_NAK=0x03.
REQ-007 Command wait (WAIT): idle until irq_i=1, then WB read of CMDR. Status decode of dat_i: bit7 DON, bit6 NAK, bit5 AL, bit4 ERR; priority AL > ERR > NAK > DON.
REQ-008 Set-bus step: DPR=req_bus, CMDR=SET_BUS, WAIT. Performed only when req_bus differs from the last successfully set bus, or on the first request after reset.
REQ-009 Sequence, in order:
- START, WAIT
- DPR={req_addr, req_rw}, CMDR=WRITE, WAIT
- data phase (REQ-010 / REQ-011)
- CMDR=STOP, WAIT
- done
REQ-010 Write byte: if wr_valid=0, FETCH stalls with no WB activity. Then wr_ready=1 for exactly 1 cycle, DPR=wr_data, CMDR=WRITE, WAIT; repeated req_len times.
REQ-011 Read byte: CMDR=READ_ACK (READ_NAK for the last byte), WAIT, WB read DPR. Then rd_valid=1 for 1 cycle with rd_data=dat_i; repeated req_len times. There is no backpressure on rd.
REQ-012 req_len=0: data phase skipped; START, address, STOP only.
REQ-013 NAK on the address or any write byte: remaining bytes are abandoned, wr_ready is not asserted again, STOP is issued, and done fires with err=01.
REQ-014 AL or ERR at any WAIT: no STOP; the last-set-bus record is invalidated; done fires with err=10 or 11.
REQ-015 done is asserted for 1 cycle with err valid in that same cycle; busy falls with done. err holds its value until the next request is accepted, where it clears to 00.
REQ-016 Byte counter is LEN_WIDTH bits and counts down; there is no wrap.

Reset
REQ-017 While rst_i=0, all outputs are 0: cyc_o, stb_o, we_o, adr_o, dat_o, req_ready, wr_ready, rd_valid, rd_data, done, err, busy. The FSM is in INIT and the bus record is invalid.
REQ-018 Reset asserted mid-transaction aborts immediately with no STOP. After release, REQ-004 repeats, followed by SET_BUS on the next request.

Verification
REQ-019 Write 0x44, bus 5, 1 byte 0x78, slave ACKs all -> WB writes in order: CSR=C0, DPR=05, CMDR=06, CMDR=04, DPR=88, CMDR=01, DPR=78, CMDR=01, CMDR=05, with CMDR reads between; done with err=00.
REQ-020 Read 0x22, bus 5, len 32, slave returns 100..131 -> address byte 0x45; CMDR=02 written 31 times then CMDR=03 once; 32 rd_valid pulses with values 100..131 in order; err=00.
REQ-021 Two back-to-back writes on bus 5 -> SET_BUS is written only in the first transaction.
REQ-022 Slave NAKs address 0x10 on a 4-byte write -> wr_ready never asserted; STOP issued; done with err=01.
REQ-023 CMDR status 0xA0 (AL) after START -> no STOP; err=10; next request re-issues SET_BUS.
REQ-024 rst_i low during byte 3 of an 8-byte read -> all outputs 0 within the same cycle; after release, CSR=C0 is the first WB access.

Source files
------------

// File: rtl/iicmb_seq.sv
// Transaction sequencer that drives an IICMB I2C master core over Wishbone.
// It turns one request into SET_BUS/START/address/data/STOP commands and reports the status.
module iicmb_seq #(
    parameter int WB_ADDR_WIDTH  = 2,
    parameter int WB_DATA_WIDTH  = 8,
    parameter int I2C_ADDR_WIDTH = 7,
    parameter int LEN_WIDTH      = 6
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_rw,
    input  logic [3:0]                req_bus,
    input  logic [I2C_ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]      req_len,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [7:0]                wr_data,
    output logic                      rd_valid,
    output logic [7:0]                rd_data,
    output logic                      done,
    output logic [1:0]                err,
    output logic                      busy,
    output logic                      cyc_o,
    output logic                      stb_o,
    output logic                      we_o,
    output logic [WB_ADDR_WIDTH-1:0]  adr_o,
    output logic [WB_DATA_WIDTH-1:0]  dat_o,
    input  logic [WB_DATA_WIDTH-1:0]  dat_i,
    input  logic                      ack_i,
    input  logic                      irq_i
);
    localparam logic [4:0] S_INIT = 5'd0,  S_IDLE = 5'd1,  S_BUS = 5'd2,  S_WAIT = 5'd3,
                           S_DEC = 5'd4,   S_SB_DPR = 5'd5, S_SB_CMD = 5'd6, S_START = 5'd7,
                           S_ADDR_DPR = 5'd8, S_ADDR_CMD = 5'd9, S_DATA = 5'd10, S_FETCH = 5'd11,
                           S_WR_DPR = 5'd12, S_WR_CMD = 5'd13, S_RD_CMD = 5'd14, S_RD_DPR = 5'd15,
                           S_RD_OUT = 5'd16, S_STOP = 5'd17, S_DONE = 5'd18;

    localparam logic [WB_ADDR_WIDTH-1:0] A_CSR  = WB_ADDR_WIDTH'(2'd0);
    localparam logic [WB_ADDR_WIDTH-1:0] A_DPR  = WB_ADDR_WIDTH'(2'd1);
    localparam logic [WB_ADDR_WIDTH-1:0] A_CMDR = WB_ADDR_WIDTH'(2'd2);

    localparam logic [7:0] C_WRITE = 8'h01, C_READ_ACK = 8'h02, C_READ_NAK = 8'h03,
                           C_START = 8'h04, C_STOP = 8'h05, C_SET_BUS = 8'h06, CSR_EN = 8'hC0;

    logic [4:0]                state_r, ret_r, cont_r;
    logic [LEN_WIDTH-1:0]      cnt_r;
    logic                      rw_r;
    logic [3:0]                req_bus_r, last_bus_r;
    logic                      bus_ok_r;
    logic [I2C_ADDR_WIDTH-1:0] i2c_addr_r;
    logic [WB_DATA_WIDTH-1:0]  rdat_r;
    logic [1:0]                pend_r, err_r;
    logic                      req_ready_r, wr_ready_r, rd_valid_r, done_r, busy_r;
    logic [7:0]                rd_data_r;
    logic                      cyc_r, stb_r, we_r;
    logic [WB_ADDR_WIDTH-1:0]  wb_adr_r;
    logic [WB_DATA_WIDTH-1:0]  wb_dat_r;

    logic                      acc_go_s, acc_we_s;
    logic [WB_ADDR_WIDTH-1:0]  acc_adr_s;
    logic [WB_DATA_WIDTH-1:0]  acc_dat_s;
    logic [4:0]                acc_ret_s, acc_cont_s;

    // Which Wishbone access each state launches; command writes return through WAIT.
    always_comb begin
        acc_go_s   = 1'b0;
        acc_we_s   = 1'b1;
        acc_adr_s  = A_CMDR;
        acc_dat_s  = {WB_DATA_WIDTH{1'b0}};
        acc_ret_s  = S_WAIT;
        acc_cont_s = cont_r;
        case (state_r)
            S_INIT:     begin acc_go_s = 1'b1; acc_adr_s = A_CSR; acc_dat_s = WB_DATA_WIDTH'(CSR_EN); acc_ret_s = S_IDLE; end
            S_SB_DPR:   begin acc_go_s = 1'b1; acc_adr_s = A_DPR; acc_dat_s = WB_DATA_WIDTH'(req_bus_r); acc_ret_s = S_SB_CMD; end
            S_SB_CMD:   begin acc_go_s = 1'b1; acc_dat_s = WB_DATA_WIDTH'(C_SET_BUS); acc_cont_s = S_START; end
            S_START:    begin acc_go_s = 1'b1; acc_dat_s = WB_DATA_WIDTH'(C_START); acc_cont_s = S_ADDR_DPR; end
            S_ADDR_DPR: begin acc_go_s = 1'b1; acc_adr_s = A_DPR; acc_dat_s = WB_DATA_WIDTH'({i2c_addr_r, rw_r}); acc_ret_s = S_ADDR_CMD; end
            S_ADDR_CMD: begin acc_go_s = 1'b1; acc_dat_s = WB_DATA_WIDTH'(C_WRITE); acc_cont_s = S_DATA; end
            S_WR_DPR:   begin acc_go_s = 1'b1; acc_adr_s = A_DPR; acc_dat_s = WB_DATA_WIDTH'(wr_data); acc_ret_s = S_WR_CMD; end
            S_WR_CMD:   begin acc_go_s = 1'b1; acc_dat_s = WB_DATA_WIDTH'(C_WRITE); acc_cont_s = S_DATA; end
            S_RD_CMD: begin
                acc_go_s   = 1'b1;
                acc_dat_s  = (cnt_r == LEN_WIDTH'(1)) ? WB_DATA_WIDTH'(C_READ_NAK) : WB_DATA_WIDTH'(C_READ_ACK);
                acc_cont_s = S_RD_DPR;
            end
            S_RD_DPR:   begin acc_go_s = 1'b1; acc_we_s = 1'b0; acc_adr_s = A_DPR; acc_ret_s = S_RD_OUT; end
            S_STOP:     begin acc_go_s = 1'b1; acc_dat_s = WB_DATA_WIDTH'(C_STOP); acc_cont_s = S_DONE; end
            S_WAIT: begin
                if (irq_i) begin
                    acc_go_s  = 1'b1;
                    acc_we_s  = 1'b0;
                    acc_ret_s = S_DEC;
                end else begin
                    acc_go_s  = 1'b0;
                end
            end
            default:    acc_go_s = 1'b0;
        endcase
    end

    // Sequencer state, Wishbone master registers and all registered outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= S_INIT;      ret_r <= S_IDLE;     cont_r <= S_IDLE;
            cnt_r <= {LEN_WIDTH{1'b0}}; rw_r <= 1'b0;    req_bus_r <= 4'd0;
            last_bus_r <= 4'd0;     bus_ok_r <= 1'b0;    i2c_addr_r <= {I2C_ADDR_WIDTH{1'b0}};
            rdat_r <= {WB_DATA_WIDTH{1'b0}};             pend_r <= 2'b00;  err_r <= 2'b00;
            req_ready_r <= 1'b0;    wr_ready_r <= 1'b0;  rd_valid_r <= 1'b0;
            rd_data_r <= 8'd0;      done_r <= 1'b0;      busy_r <= 1'b0;
            cyc_r <= 1'b0;          stb_r <= 1'b0;       we_r <= 1'b0;
            wb_adr_r <= {WB_ADDR_WIDTH{1'b0}};           wb_dat_r <= {WB_DATA_WIDTH{1'b0}};
        end else begin
            done_r     <= 1'b0;
            rd_valid_r <= 1'b0;
            wr_ready_r <= 1'b0;
            if (acc_go_s) begin
                cyc_r    <= 1'b1;
                stb_r    <= 1'b1;
                we_r     <= acc_we_s;
                wb_adr_r <= acc_adr_s;
                wb_dat_r <= acc_dat_s;
                ret_r    <= acc_ret_s;
                cont_r   <= acc_cont_s;
                state_r  <= S_BUS;
            end
            case (state_r)
                S_IDLE: begin
                    if (req_valid && req_ready_r) begin
                        req_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        err_r       <= 2'b00;
                        pend_r      <= 2'b00;
                        rw_r        <= req_rw;
                        req_bus_r   <= req_bus;
                        i2c_addr_r  <= req_addr;
                        cnt_r       <= req_len;
                        state_r     <= (bus_ok_r && last_bus_r == req_bus) ? S_START : S_SB_DPR;
                    end
                end
                S_BUS: begin
                    if (ack_i) begin
                        cyc_r   <= 1'b0;
                        stb_r   <= 1'b0;
                        rdat_r  <= dat_i;
                        state_r <= ret_r;
                        if (ret_r == S_IDLE) begin
                            req_ready_r <= 1'b1;
                        end
                    end
                end
                // Status priority AL > ERR > NAK > DON; a status with none of them is a controller fault.
                S_DEC: begin
                    if (rdat_r[5]) begin
                        pend_r <= 2'b10; bus_ok_r <= 1'b0; state_r <= S_DONE;
                    end else if (rdat_r[4]) begin
                        pend_r <= 2'b11; bus_ok_r <= 1'b0; state_r <= S_DONE;
                    end else if (rdat_r[6]) begin
                        pend_r  <= 2'b01;
                        state_r <= (cont_r == S_DONE) ? S_DONE : S_STOP;
                    end else if (rdat_r[7]) begin
                        if (cont_r == S_START) begin
                            bus_ok_r   <= 1'b1;
                            last_bus_r <= req_bus_r;
                        end
                        state_r <= cont_r;
                    end else begin
                        pend_r <= 2'b11; bus_ok_r <= 1'b0; state_r <= S_DONE;
                    end
                end
                S_DATA: begin
                    if (cnt_r == {LEN_WIDTH{1'b0}}) state_r <= S_STOP;
                    else if (rw_r)                  state_r <= S_RD_CMD;
                    else                            state_r <= S_FETCH;
                end
                S_FETCH: begin
                    if (wr_valid) begin
                        wr_ready_r <= 1'b1;
                        state_r    <= S_WR_DPR;
                    end
                end
                S_WR_DPR, S_RD_CMD: cnt_r <= cnt_r - LEN_WIDTH'(1);
                S_RD_OUT: begin
                    rd_valid_r <= 1'b1;
                    rd_data_r  <= rdat_r[7:0];
                    state_r    <= S_DATA;
                end
                S_DONE: begin
                    done_r      <= 1'b1;
                    busy_r      <= 1'b0;
                    err_r       <= pend_r;
                    req_ready_r <= 1'b1;
                    state_r     <= S_IDLE;
                end
                S_INIT, S_WAIT, S_SB_DPR, S_SB_CMD, S_START, S_ADDR_DPR,
                S_ADDR_CMD, S_WR_CMD, S_RD_DPR, S_STOP: ;
                default: state_r <= S_INIT;
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign wr_ready  = wr_ready_r;
    assign rd_valid  = rd_valid_r;
    assign rd_data   = rd_data_r;
    assign done      = done_r;
    assign err       = err_r;
    assign busy      = busy_r;
    assign cyc_o     = cyc_r;
    assign stb_o     = stb_r;
    assign we_o      = we_r;
    assign adr_o     = wb_adr_r;
    assign dat_o     = wb_dat_r;
endmodule

// File: tb/tb_iicmb_seq.sv
// Directed bench for iicmb_seq with a small Wishbone/IICMB responder model.
module tb_iicmb_seq;
    logic       clk_i = 1'b0, rst_i = 1'b0;
    logic       req_valid = 1'b0, req_rw = 1'b0;
    logic [3:0] req_bus = 4'd0;
    logic [6:0] req_addr = 7'd0;
    logic [5:0] req_len = 6'd0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'd0;
    logic       req_ready, wr_ready, rd_valid, done, busy, cyc_o, stb_o, we_o;
    logic [7:0] rd_data, dat_o;
    logic [1:0] err, adr_o;
    logic [7:0] dat_i = 8'd0;
    logic       ack_i = 1'b0, irq_i = 1'b0;

    logic [9:0] wlog[$];
    logic [7:0] rlog[$];
    int cmd_total = 0, cmd_base = 0, force_idx = 0;
    logic [7:0] force_val = 8'h80;
    int dpr_reads = 0, dpr_base = 0, wr_pulses = 0, irq_cnt = 0;
    int checks = 0, errors = 0;

    iicmb_seq dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_valid(req_valid), .req_ready(req_ready),
        .req_rw(req_rw), .req_bus(req_bus), .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err), .busy(busy),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
        .dat_i(dat_i), .ack_i(ack_i), .irq_i(irq_i)
    );

    always #5 clk_i = ~clk_i;

    // Responder: one-cycle ack, logs writes, irq a few cycles after each command write.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            ack_i = 1'b0; irq_i = 1'b0; irq_cnt = 0;
        end else begin
            if (irq_cnt > 0) begin
                irq_cnt--;
                if (irq_cnt == 0) irq_i = 1'b1;
            end
            if (cyc_o && stb_o && !ack_i) begin
                ack_i = 1'b1;
                if (we_o) begin
                    wlog.push_back({adr_o, dat_o});
                    if (adr_o == 2'd2) begin cmd_total++; irq_cnt = 3; end
                end else if (adr_o == 2'd2) begin
                    dat_i = ((cmd_total - cmd_base) == force_idx) ? force_val : 8'h80;
                    irq_i = 1'b0;
                end else begin
                    dat_i = 8'(100 + dpr_reads - dpr_base);
                    dpr_reads++;
                end
            end else begin
                ack_i = 1'b0;
            end
        end
    end

    always @(negedge clk_i) begin
        if (rd_valid) rlog.push_back(rd_data);
        if (wr_ready) wr_pulses++;
    end

    function automatic int first_diff(int mark, logic [9:0] exp[$]);
        for (int i = 0; i < exp.size(); i++)
            if (mark + i >= wlog.size() || wlog[mark + i] !== exp[i]) return i;
        if (wlog.size() - mark > exp.size()) return exp.size();
        return -1;
    endfunction

    function automatic logic [9:0] got_at(int idx);
        return (idx < wlog.size()) ? wlog[idx] : 10'h3FF;
    endfunction

    function automatic logic [9:0] want_at(logic [9:0] exp[$], int idx);
        return (idx < exp.size()) ? exp[idx] : 10'h3FF;
    endfunction

    task automatic run_req(input logic rw, input logic [3:0] bus, input logic [6:0] addr,
                           input logic [5:0] len, output logic [1:0] got_err);
        int n;
        got_err = 2'bxx;
        @(negedge clk_i);
        req_valid = 1'b1; req_rw = rw; req_bus = bus; req_addr = addr; req_len = len;
        n = 0;
        while (!req_ready && n < 2000) begin @(negedge clk_i); n++; end
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL accept: req_ready=%b want 1", req_ready); end
        @(negedge clk_i);
        req_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_accept: busy=%b want 1", busy); end
        checks++;
        if (err !== 2'b00) begin errors++; $display("FAIL err_cleared: err=%b want 00", err); end
        n = 0;
        while (!done && n < 20000) begin @(negedge clk_i); n++; end
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL done_timeout: done=%b want 1", done);
        end else begin
            got_err = err;
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done: busy=%b want 0", busy); end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_i);
        checks++;
        if ({cyc_o, stb_o, we_o, adr_o, dat_o, req_ready, wr_ready, rd_valid, rd_data, done, err, busy} !== 28'h0) begin
            errors++; $display("FAIL reset_outputs: cyc=%b req_ready=%b busy=%b dat_o=%h want all 0", cyc_o, req_ready, busy, dat_o);
        end
        rst_i = 1'b1;
    endtask

    task automatic test_init();
        int n = 0;
        while (!req_ready && n < 200) begin @(negedge clk_i); n++; end
        checks++;
        if (req_ready !== 1'b1 || wlog.size() != 1 || wlog[0] !== 10'h0C0) begin
            errors++; $display("FAIL init_csr: req_ready=%b log_size=%0d first=%h want 1/1/0c0", req_ready, wlog.size(), got_at(0));
        end
    endtask

    task automatic test_write();
        logic [9:0] exp[$];
        logic [1:0] e;
        int d, wp0 = wr_pulses;
        exp = '{10'h0C0, 10'h105, 10'h206, 10'h204, 10'h188, 10'h201, 10'h178, 10'h201, 10'h205};
        wr_valid = 1'b1; wr_data = 8'h78;
        run_req(1'b0, 4'd5, 7'h44, 6'd1, e);
        wr_valid = 1'b0;
        d = first_diff(0, exp);
        checks++;
        if (d >= 0) begin errors++; $display("FAIL write_seq: entry %0d got %h want %h", d, got_at(d), want_at(exp, d)); end
        checks++;
        if (e !== 2'b00) begin errors++; $display("FAIL write_err: err=%b want 00", e); end
        checks++;
        if (wr_pulses - wp0 != 1) begin errors++; $display("FAIL write_wr_ready: pulses=%0d want 1", wr_pulses - wp0); end
    endtask

    task automatic test_read();
        logic [9:0] exp[$];
        logic [1:0] e;
        int d, bad = -1, mark = wlog.size(), r0 = rlog.size();
        exp = '{10'h204, 10'h145, 10'h201};
        for (int i = 0; i < 31; i++) exp.push_back(10'h202);
        exp.push_back(10'h203);
        exp.push_back(10'h205);
        dpr_base = dpr_reads;
        run_req(1'b1, 4'd5, 7'h22, 6'd32, e);
        d = first_diff(mark, exp);
        checks++;
        if (d >= 0) begin errors++; $display("FAIL read_seq: entry %0d got %h want %h", d, got_at(mark + d), want_at(exp, d)); end
        checks++;
        if (rlog.size() - r0 != 32) begin errors++; $display("FAIL read_count: got %0d want 32", rlog.size() - r0); end
        for (int i = 0; i < 32 && r0 + i < rlog.size(); i++)
            if (bad < 0 && rlog[r0 + i] !== 8'(100 + i)) bad = i;
        checks++;
        if (bad >= 0) begin errors++; $display("FAIL read_data: byte %0d got %0d want %0d", bad, rlog[r0 + bad], 100 + bad); end
        checks++;
        if (e !== 2'b00) begin errors++; $display("FAIL read_err: err=%b want 00", e); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp[$];
        logic [1:0] e;
        int d, mark = wlog.size();
        exp = '{10'h103, 10'h206, 10'h204, 10'h160, 10'h201, 10'h15A, 10'h201, 10'h205};
        wr_valid = 1'b1; wr_data = 8'h5A;
        run_req(1'b0, 4'd3, 7'h30, 6'd1, e);
        wr_valid = 1'b0;
        d = first_diff(mark, exp);
        checks++;
        if (d >= 0) begin errors++; $display("FAIL b2b_first_seq: entry %0d got %h want %h", d, got_at(mark + d), want_at(exp, d)); end
        mark = wlog.size();
        exp = '{10'h204, 10'h162, 10'h201, 10'h205};
        run_req(1'b0, 4'd3, 7'h31, 6'd0, e);
        d = first_diff(mark, exp);
        checks++;
        if (d >= 0) begin errors++; $display("FAIL b2b_probe_seq: entry %0d got %h want %h", d, got_at(mark + d), want_at(exp, d)); end
        checks++;
        if (e !== 2'b00) begin errors++; $display("FAIL b2b_err: err=%b want 00", e); end
    endtask

    task automatic test_nak();
        logic [9:0] exp[$];
        logic [1:0] e;
        int d, mark = wlog.size(), wp0 = wr_pulses;
        exp = '{10'h204, 10'h120, 10'h201, 10'h205};
        cmd_base = cmd_total; force_idx = 2; force_val = 8'hC0;
        wr_valid = 1'b1; wr_data = 8'h33;
        run_req(1'b0, 4'd3, 7'h10, 6'd4, e);
        wr_valid = 1'b0; force_idx = 0;
        d = first_diff(mark, exp);
        checks++;
        if (d >= 0) begin errors++; $display("FAIL nak_seq: entry %0d got %h want %h", d, got_at(mark + d), want_at(exp, d)); end
        checks++;
        if (wr_pulses != wp0) begin errors++; $display("FAIL nak_wr_ready: pulses=%0d want 0", wr_pulses - wp0); end
        checks++;
        if (e !== 2'b01) begin errors++; $display("FAIL nak_err: err=%b want 01", e); end
    endtask

    task automatic test_arb_lost();
        logic [9:0] exp[$];
        logic [1:0] e;
        int d, mark = wlog.size();
        exp = '{10'h204};
        cmd_base = cmd_total; force_idx = 1; force_val = 8'hA0;
        run_req(1'b0, 4'd3, 7'h11, 6'd0, e);
        force_idx = 0;
        d = first_diff(mark, exp);
        checks++;
        if (d >= 0) begin errors++; $display("FAIL al_seq: entry %0d got %h want %h", d, got_at(mark + d), want_at(exp, d)); end
        checks++;
        if (e !== 2'b10) begin errors++; $display("FAIL al_err: err=%b want 10", e); end
        checks++;
        if (err !== 2'b10) begin errors++; $display("FAIL al_err_hold: err=%b want 10", err); end
        mark = wlog.size();
        exp = '{10'h103, 10'h206, 10'h204, 10'h122, 10'h201, 10'h205};
        run_req(1'b0, 4'd3, 7'h11, 6'd0, e);
        d = first_diff(mark, exp);
        checks++;
        if (d >= 0) begin errors++; $display("FAIL al_rebus_seq: entry %0d got %h want %h", d, got_at(mark + d), want_at(exp, d)); end
    endtask

    task automatic test_reset_mid();
        logic [9:0] exp[$];
        logic [1:0] e;
        int d, n, mark, r0 = rlog.size();
        @(negedge clk_i);
        req_valid = 1'b1; req_rw = 1'b1; req_bus = 4'd3; req_addr = 7'h12; req_len = 6'd8;
        n = 0;
        while (!req_ready && n < 2000) begin @(negedge clk_i); n++; end
        @(negedge clk_i);
        req_valid = 1'b0;
        n = 0;
        while (rlog.size() - r0 < 2 && n < 5000) begin @(negedge clk_i); n++; end
        n = 0;
        while (!cyc_o && n < 500) begin @(negedge clk_i); n++; end
        checks++;
        if (rlog.size() - r0 != 2 || cyc_o !== 1'b1) begin
            errors++; $display("FAIL mid_reach_byte3: bytes=%0d cyc=%b want 2/1", rlog.size() - r0, cyc_o);
        end
        rst_i = 1'b0;
        #1;
        checks++;
        if ({cyc_o, stb_o, we_o, adr_o, dat_o, req_ready, wr_ready, rd_valid, rd_data, done, err, busy} !== 28'h0) begin
            errors++; $display("FAIL mid_reset_outputs: cyc=%b busy=%b adr=%h dat_o=%h want all 0", cyc_o, busy, adr_o, dat_o);
        end
        repeat (2) @(negedge clk_i);
        mark = wlog.size();
        rst_i = 1'b1;
        n = 0;
        while (wlog.size() <= mark && n < 200) begin @(negedge clk_i); n++; end
        checks++;
        if (wlog.size() <= mark || wlog[mark] !== 10'h0C0) begin
            errors++; $display("FAIL mid_first_access: got %h want 0c0", got_at(mark));
        end
        mark = wlog.size();
        exp = '{10'h103, 10'h206, 10'h204, 10'h126, 10'h201, 10'h205};
        run_req(1'b0, 4'd3, 7'h13, 6'd0, e);
        d = first_diff(mark, exp);
        checks++;
        if (d >= 0) begin errors++; $display("FAIL mid_rebus_seq: entry %0d got %h want %h", d, got_at(mark + d), want_at(exp, d)); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_write();
        test_read();
        test_back_to_back();
        test_nak();
        test_arb_lost();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
